// File: rtl/mod_mul_sched_if.sv
// Signal bundle between mod_mul_sched, its requesters and the shared modular multiplier.
// valid/ready: a transfer completes on a rising clk edge with both high; valid may drop before that edge (withdrawal).
interface mod_mul_sched_if #(
   parameter int NBITS = 4,
   parameter int NREQ  = 2
);
   localparam int MW = (NBITS > 1) ? $clog2(NBITS) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*NBITS-1:0] req_a;
   logic [NREQ*NBITS-1:0] req_b;
   logic [NREQ*NBITS-1:0] req_m;
   logic [NREQ*MW-1:0]    req_m_msb;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [NBITS-1:0]      rsp_y;
   logic                  rsp_err;
   logic                  mm_enable_p;
   logic [NBITS-1:0]      mm_a;
   logic [NBITS-1:0]      mm_b;
   logic [NBITS-1:0]      mm_m;
   logic [MW-1:0]         mm_m_msb;
   logic [NBITS-1:0]      mm_y;
   logic                  mm_done_irq_p;

   modport slave (
      input  req_valid, req_a, req_b, req_m, req_m_msb, rsp_ready, mm_y, mm_done_irq_p,
      output req_ready, rsp_valid, rsp_y, rsp_err, mm_enable_p, mm_a, mm_b, mm_m, mm_m_msb
   );

   modport master (
      output req_valid, req_a, req_b, req_m, req_m_msb, rsp_ready, mm_y, mm_done_irq_p,
      input  req_ready, rsp_valid, rsp_y, rsp_err, mm_enable_p, mm_a, mm_b, mm_m, mm_m_msb
   );
endinterface

// File: rtl/mod_mul_sched.sv
// Round-robin scheduler sharing one modular multiplier (y = a*b mod m) among NREQ requesters.
// Build macro MMS_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT_CYCLES cycles.
module mod_mul_sched #(
   parameter int NBITS          = 4,
   parameter int NREQ           = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   mod_mul_sched_if.slave bus,
   output logic [1:0]     o_dbg_state
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int MW = (NBITS > 1) ? $clog2(NBITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_BUSY   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    r_grant;
   logic [IW-1:0]    w_grant;
   logic             w_found;
   logic             w_accept;
   logic             w_m_zero;
   logic             w_timeout;
   logic             w_mm_enable;
   logic [NREQ-1:0]  w_req_ready;
   logic [NREQ-1:0]  w_rsp_valid;
   logic [NBITS-1:0] r_a;
   logic [NBITS-1:0] r_b;
   logic [NBITS-1:0] r_m;
   logic [MW-1:0]    r_m_msb;
   logic [NBITS-1:0] r_y;
   logic             r_err;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int step);
      int sum;
      sum = int'(base) + step;
      if (sum >= NREQ) sum = sum - NREQ;
      return IW'(sum);
   endfunction

   // Scan downward so the lowest offset from the pointer wins.
   always_comb begin
      w_found = 1'b0;
      w_grant = r_ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req_valid[wrap_inc(r_ptr, k)]) begin
            w_found = 1'b1;
            w_grant = wrap_inc(r_ptr, k);
         end
      end
   end

   assign w_accept = (r_state == S_IDLE) && w_found;
   assign w_m_zero = (r_m == '0);

   always_comb begin
      w_req_ready = '0;
      w_rsp_valid = '0;
      if (w_accept) w_req_ready[w_grant] = 1'b1;
      if (r_state == S_RESP) w_rsp_valid[r_grant] = 1'b1;
   end

`ifdef MMS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_to_cnt <= '0;
      else if (r_state != S_BUSY) r_to_cnt <= '0;
      else                       r_to_cnt <= r_to_cnt + 1'b1;
   end

   assign w_timeout = (r_state == S_BUSY) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog compiled out: BUSY waits for done indefinitely.
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_mm_enable = 1'b0;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_LAUNCH;
         S_LAUNCH: begin
            w_mm_enable = !w_m_zero;
            w_state_nxt = w_m_zero ? S_RESP : S_BUSY;
         end
         S_BUSY:   if (bus.mm_done_irq_p || w_timeout) w_state_nxt = S_RESP;
         S_RESP:   if (bus.rsp_ready[r_grant]) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_grant <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_m     <= '0;
         r_m_msb <= '0;
         r_y     <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a     <= bus.req_a[int'(w_grant)*NBITS +: NBITS];
            r_b     <= bus.req_b[int'(w_grant)*NBITS +: NBITS];
            r_m     <= bus.req_m[int'(w_grant)*NBITS +: NBITS];
            r_m_msb <= bus.req_m_msb[int'(w_grant)*MW +: MW];
            r_grant <= w_grant;
            r_ptr   <= wrap_inc(w_grant, 1);
            r_err   <= 1'b0;
         end
         if ((r_state == S_LAUNCH) && w_m_zero) begin
            r_y   <= '0;
            r_err <= 1'b1;
         end
         // done has priority over a coincident watchdog expiry
         if (r_state == S_BUSY) begin
            if (bus.mm_done_irq_p) begin
               r_y   <= bus.mm_y;
               r_err <= 1'b0;
            end else if (w_timeout) begin
               r_y   <= '0;
               r_err <= 1'b1;
            end
         end
      end
   end

   assign bus.req_ready   = w_req_ready;
   assign bus.rsp_valid   = w_rsp_valid;
   assign bus.rsp_y       = r_y;
   assign bus.rsp_err     = r_err;
   assign bus.mm_enable_p = w_mm_enable;
   assign bus.mm_a        = r_a;
   assign bus.mm_b        = r_b;
   assign bus.mm_m        = r_m;
   assign bus.mm_m_msb    = r_m_msb;
   assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_mod_mul_sched.sv
// Directed + randomized bench for mod_mul_sched with a behavioural multiplier and a response scoreboard.
// Also covers the MMS_TIMEOUT_EN build when that macro is defined.
module tb_mod_mul_sched;
   localparam int NBITS = 4;
   localparam int NREQ  = 2;
   localparam int MW    = 2;
   localparam int EW    = 1 + NBITS + NREQ;
`ifdef MMS_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_BUSY   = 2'd2;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       dbg_state;
   int               errors = 0;
   int               checks = 0;
   logic [EW-1:0]    exp_q[$];
   logic [NBITS-1:0] op_a[NREQ];
   logic [NBITS-1:0] op_b[NREQ];
   logic [NBITS-1:0] op_m[NREQ];
   int               ptr_model   = 0;
   int               exp_starts  = 0;
   int               mm_starts   = 0;
   int               mm_lat      = 2;
   int               spur_req    = 0;
   int               spur_done   = 0;
   bit               mm_suppress = 1'b0;

   mod_mul_sched_if #(.NBITS(NBITS), .NREQ(NREQ)) bus ();

   mod_mul_sched #(.NBITS(NBITS), .NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // behavioural multiplier: done pulse mm_lat cycles after the start cycle
   initial begin : mm_model
      int cnt;
      logic [NBITS-1:0] res;
      cnt = 0;
      res = '0;
      bus.mm_done_irq_p = 1'b0;
      bus.mm_y = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mm_done_irq_p = 1'b0;
         if (!rst_n) begin
            cnt = 0;
         end else begin
            if (spur_req != spur_done) begin
               bus.mm_done_irq_p = 1'b1;
               bus.mm_y = 4'hF;
               spur_done++;
            end
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0 && !mm_suppress) begin
                  bus.mm_done_irq_p = 1'b1;
                  bus.mm_y = res;
               end
            end
            if (bus.mm_enable_p) begin
               if (bus.mm_m != '0) res = NBITS'((int'(bus.mm_a) * int'(bus.mm_b)) % int'(bus.mm_m));
               else res = '0;
               cnt = mm_lat;
               mm_starts++;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MW-1:0] msb_of(input logic [NBITS-1:0] m);
      logic [MW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NBITS; i++) if (m[i]) idx = MW'(i);
      return idx;
   endfunction

   function automatic int model_grant(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) if (v[(ptr_model + k) % NREQ]) return (ptr_model + k) % NREQ;
      return 0;
   endfunction

   // driver tasks
   task automatic set_req(input int r, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                          input logic [NBITS-1:0] m);
      op_a[r] = a;
      op_b[r] = b;
      op_m[r] = m;
      bus.req_a[r*NBITS +: NBITS] = a;
      bus.req_b[r*NBITS +: NBITS] = b;
      bus.req_m[r*NBITS +: NBITS] = m;
      bus.req_m_msb[r*MW +: MW] = msb_of(m);
   endtask

   task automatic push_exp(input int g);
      logic [NBITS-1:0] y;
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[g] = 1'b1;
      if (op_m[g] == '0) y = '0;
      else y = NBITS'((int'(op_a[g]) * int'(op_b[g])) % int'(op_m[g]));
      exp_q.push_back({op_m[g] == '0, y, oh});
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the LAUNCH cycle.
   task automatic accept(input logic [NREQ-1:0] v, output int g);
      logic [NREQ-1:0] oh;
      bus.req_valid = v;
      #1;
      g = model_grant(v);
      oh = '0;
      oh[g] = 1'b1;
      check("req_ready", bus.req_ready, oh);
      push_exp(g);
      ptr_model = (g + 1) % NREQ;
      if (op_m[g] != '0) exp_starts++;
      @(negedge clk);
      check("launch_state", dbg_state, ST_LAUNCH);
      check("mm_enable_p", bus.mm_enable_p, op_m[g] != '0);
      check("mm_a", bus.mm_a, op_a[g]);
      check("mm_b", bus.mm_b, op_b[g]);
      check("mm_m", bus.mm_m, op_m[g]);
      check("mm_m_msb", bus.mm_m_msb, msb_of(op_m[g]));
   endtask

   // Waits for the response, checks it against the scoreboard for bp+1 cycles, then handshakes.
   task automatic complete(input string tag, input int exp_cyc, input int bp);
      int cyc;
      logic [EW-1:0] e;
      cyc = 0;
      while (bus.rsp_valid == '0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, cyc, exp_cyc);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      for (int i = 0; i <= bp; i++) begin
         check({tag, "_rsp_valid"}, bus.rsp_valid, e[NREQ-1:0]);
         check({tag, "_rsp_y"}, bus.rsp_y, e[NREQ +: NBITS]);
         check({tag, "_rsp_err"}, bus.rsp_err, e[EW-1]);
         check({tag, "_req_ready_busy"}, bus.req_ready, 0);
         if (i < bp) @(negedge clk);
      end
      bus.rsp_ready = e[NREQ-1:0];
      @(negedge clk);
      bus.rsp_ready = '0;
      check({tag, "_rsp_clear"}, bus.rsp_valid, 0);
      check({tag, "_starts"}, mm_starts, exp_starts);
   endtask

   initial begin : main
      int g;
      logic [NREQ-1:0] v;
      logic [NBITS-1:0] m;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_m = '0;
      bus.req_m_msb = '0;
      bus.rsp_ready = '0;
      for (int r = 0; r < NREQ; r++) set_req(r, '0, '0, '0);

      // reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_rsp_y", bus.rsp_y, 0);
      check("rst_mm_enable_p", bus.mm_enable_p, 0);
      check("rst_mm_a", bus.mm_a, 0);
      check("rst_mm_m", bus.mm_m, 0);
      check("rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      @(negedge clk);

      // single request: 5*6 mod 7 = 2
      set_req(0, 4'd5, 4'd6, 4'd7);
      mm_lat = 3;
      accept(2'b01, g);
      bus.req_valid = '0;
      @(negedge clk);
      check("single_pulse_once", bus.mm_enable_p, 0);
      check("single_busy", dbg_state, ST_BUSY);
      check("single_hold_a", bus.mm_a, 4'd5);
      complete("single", mm_lat, 0);

      // m == 0 on requester 1: no launch, error response two cycles after acceptance
      set_req(1, 4'd3, 4'd3, 4'd0);
      accept(2'b10, g);
      bus.req_valid = '0;
      complete("mzero", 1, 0);

      // contention: both valid continuously, grants rotate
      set_req(0, 4'd3, 4'd4, 4'd5);
      set_req(1, 4'd6, 4'd6, 4'd11);
      mm_lat = 2;
      for (int i = 0; i < 3; i++) begin
         accept(2'b11, g);
         check("cont_grant", g, i % 2);
         complete("cont", mm_lat + 1, 0);
      end
      bus.req_valid = '0;
      @(negedge clk);
      check("withdraw_idle", dbg_state, ST_IDLE);

      // backpressure on requester 0 while requester 1 waits
      set_req(0, 4'd7, 4'd9, 4'd10);
      set_req(1, 4'd2, 4'd5, 4'd3);
      accept(2'b01, g);
      bus.req_valid = 2'b10;
      complete("bp", mm_lat + 1, 10);
      accept(2'b10, g);
      bus.req_valid = '0;
      complete("bp_r1", mm_lat + 1, 0);

      // done pulse outside BUSY is ignored
      spur_req++;
      repeat (3) @(negedge clk);
      check("spur_state", dbg_state, ST_IDLE);
      check("spur_rsp_valid", bus.rsp_valid, 0);

      // asynchronous reset while BUSY
      set_req(0, 4'd9, 4'd7, 4'd13);
      mm_lat = 20;
      accept(2'b01, g);
      bus.req_valid = '0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", dbg_state, ST_BUSY);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", dbg_state, ST_IDLE);
      check("arst_mm_a", bus.mm_a, 0);
      check("arst_mm_m", bus.mm_m, 0);
      check("arst_mm_m_msb", bus.mm_m_msb, 0);
      check("arst_rsp_y", bus.rsp_y, 0);
      check("arst_rsp_valid", bus.rsp_valid, 0);
      exp_q.delete();
      ptr_model = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mm_lat = 2;
      set_req(0, 4'd11, 4'd13, 4'd14);
      set_req(1, 4'd4, 4'd4, 4'd9);
      accept(2'b11, g);
      bus.req_valid = '0;
      complete("post_rst", mm_lat + 1, 0);

      // randomized traffic
      for (int it = 0; it < 24; it++) begin
         v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int r = 0; r < NREQ; r++) begin
            if ($urandom_range(0, 4) == 0) m = '0;
            else m = NBITS'($urandom_range(1, 15));
            set_req(r, NBITS'($urandom), NBITS'($urandom), m);
         end
         mm_lat = $urandom_range(1, 6);
         accept(v, g);
         bus.req_valid = '0;
         complete("rand", (op_m[g] == '0) ? 1 : mm_lat + 1, $urandom_range(0, 3));
      end

`ifdef MMS_TIMEOUT_EN
      // watchdog: done suppressed, error after TO BUSY cycles, late done ignored
      mm_suppress = 1'b1;
      mm_lat = 2;
      set_req(1, 4'd7, 4'd5, 4'd9);
      accept(2'b10, g);
      bus.req_valid = '0;
      void'(exp_q.pop_back());
      exp_q.push_back({1'b1, {NBITS{1'b0}}, 2'b10});
      complete("timeout", TO + 1, 0);
      mm_suppress = 1'b0;
      spur_req++;
      repeat (3) @(negedge clk);
      check("late_done_state", dbg_state, ST_IDLE);
      check("late_done_rsp_valid", bus.rsp_valid, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
